debug_selector: RTL and testbench
=================================

# debug_selector

Debounced push-button front end that chooses which measurement the 7-segment debug display shows. Two active-low keys step forwards and backwards through the display modes, with hold-to-repeat. A registered one-hot select code (`SEL`) feeds the display multiplexer's `DSW` input. A non-zero DIP-switch word overrides the key-selected mode, so the board behaves as before whenever a switch is set.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000, is the number of consecutive cycles a synchronized key must differ from its debounced state before that state flips (20 ms at 50 MHz). Minimum value is 1.
- `REPEAT_CYCLES`, default 25_000_000, is the auto-repeat period while a key is held. A value of 0 disables repeat.
- `CLK`, input, 1 bit: system clock. This is the only clock.
- `RESET`, input, 1 bit: synchronous, active-high reset.
- `KEY_UP`, input, 1 bit: asynchronous, active-low. Steps the mode forward.
- `KEY_DOWN`, input, 1 bit: asynchronous, active-low. Steps the mode backward.
- `DSW`, input, 8 bits: DIP-switch override. Any non-zero value takes priority in `SEL`.
- `SEL`, output, 8 bits: registered select code for the display multiplexer.
- `MODE`, output, 3 bits: current key-selected mode index.
- `CHANGE`, output, 1 bit: one-cycle pulse, asserted in the cycle `MODE` takes a new value.

## Operation
- **Mode table** (`MODE` → code):
  - 0 → 0x00, shows "--"
  - 1 → 0x01, PHI
  - 2 → 0x02, ZVS
  - 3 → 0x04, DEADTIME
  - 4 → 0x10, Vbat HEX
  - 5 → 0x20, Ibat HEX
  - 6 → 0x40, Vbat DEC
  - 7 → 0x80, Ibat DEC
- **Synchronizer:** each key passes through its own 2-flop synchronizer. `DSW` is sampled directly, since it is quasi-static.
- **Debouncer (per key):**
  - Holds a debounced state `stable` and a counter `cnt`.
  - When the synchronized value equals `stable`, `cnt` is cleared to 0.
  - Otherwise `cnt` increments. When `cnt` reaches `DEBOUNCE_CYCLES-1` while still differing, `stable` takes the synchronized value and `cnt` clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` leaves `stable` unchanged.
- **Press event:** raised when `stable` goes from 1 to 0. Release (0 to 1) generates no event.
- **Repeat:**
  - While `stable` is 0 and `REPEAT_CYCLES` is greater than 0, a hold counter runs.
  - An additional event fires every `REPEAT_CYCLES` cycles, measured from the press event.
  - The hold counter clears on release.
- **Mode update:**
  - Up event alone: `MODE` becomes `MODE+1` mod 8, so 7 wraps to 0.
  - Down event alone: `MODE` becomes `MODE-1` mod 8, so 0 wraps to 7.
  - Up and down events in the same cycle: `MODE` becomes 0, and `CHANGE` pulses only if `MODE` was non-zero.
- **CHANGE:** pulses only when the new `MODE` differs from the old one.
- **SEL:** registered every cycle. Equals `DSW` if `DSW != 0`, otherwise the table code for `MODE`.
- **Keys during override:** key events still update `MODE` and `CHANGE` while `DSW` overrides `SEL`. Clearing `DSW` then shows the current mode.

## Timing
- **Reset values:**
  - `MODE` = 0, `SEL` = 0x00, `CHANGE` = 0.
  - Synchronizers and `stable` = 1 (released).
  - All counters = 0.
- **Press latency:**
  - Key falls; first `CLK` edge samples 0: edge 1.
  - Synchronized output is 0 after edge 2.
  - `stable` flips at edge 2+`DEBOUNCE_CYCLES`.
  - `MODE`, `CHANGE`, and the table-driven `SEL` update at edge 3+`DEBOUNCE_CYCLES`.
  - `SEL` follows the new `MODE` in the same edge, not one cycle later.
- **DSW latency:** 1 cycle from `DSW` to `SEL`.
- **Repeat timing:** the first repeat event occurs `REPEAT_CYCLES` cycles after the press event; subsequent events follow at the same spacing.
- **Reset mid-operation:** all state returns to reset values in the cycle after `RESET` is sampled high. A key held through reset release is treated as a new press and fires after the full press latency.
- **Debounce during reset:** debounce counting is suspended while `RESET` is high.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `REPEAT_CYCLES`=16 in simulation.

1. **Reset:** hold `RESET` 3 cycles with `DSW`=0 → `SEL`=0x00, `MODE`=0, `CHANGE`=0.
2. **Single step up:** `KEY_UP` low for 10 cycles → `MODE`=1, `SEL`=0x01, `CHANGE` high exactly 1 cycle at edge 7. Release → no further change.
3. **Glitch and wrap:**
   - `KEY_DOWN` low for 3 cycles → no change.
   - `KEY_DOWN` low for 6 cycles from `MODE`=0 → `MODE`=7, `SEL`=0x80.
   - Then 8 `KEY_UP` presses → `MODE` back to 7, each press producing one `CHANGE` pulse.
4. **Hold-to-repeat:** hold `KEY_UP` for 60 cycles from `MODE`=0 → `MODE` sequence 1, 2, 3, 4. Updates at edges 7, 23, 39, 55.
5. **Simultaneous events:** from `MODE`=5, press both keys with identical waveforms → `MODE`=0, `SEL`=0x00, one `CHANGE` pulse.
6. **Override and reset mid-press:**
   - `DSW`=0x20 with `MODE`=2 → `SEL`=0x20 after 1 cycle.
   - Press `KEY_UP` → `MODE`=3, `SEL` stays 0x20.
   - `DSW`=0 → `SEL`=0x04.
   - Assert `RESET` while `KEY_UP` is held → `MODE`=0. After release of `RESET` → `MODE`=1 at 7 edges.

Source files
------------

// File: rtl/debug_selector.sv
// -----------------------------------------------------------------------------
// debug_selector
//
// Push-button front end for the 7-segment debug display. Two active-low keys
// step a 3-bit mode index forwards/backwards (with hold-to-repeat). The mode is
// translated to a one-hot select code for the display multiplexer. A non-zero
// DIP-switch word replaces the key-selected code.
//
// Ports
//   CLK      in   1  system clock (only clock)
//   RESET    in   1  synchronous, active-high reset
//   KEY_UP   in   1  asynchronous, active-low: step mode forward
//   KEY_DOWN in   1  asynchronous, active-low: step mode backward
//   DSW      in   8  DIP-switch override (non-zero wins)
//   SEL      out  8  registered select code for the display mux
//   MODE     out  3  current key-selected mode index
//   CHANGE   out  1  one-cycle pulse in the cycle MODE takes a new value
// -----------------------------------------------------------------------------

// Per-key synchronizer, debouncer, press detector and auto-repeat generator.
//   clk_i    in   1  clock
//   rst_i    in   1  synchronous, active-high reset
//   key_ni   in   1  raw active-low key
//   event_o  out  1  one-cycle step request (press or repeat)
module debug_selector_key #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_CYCLES   = 25_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_ni,
    output logic event_o
);
    localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned HW = (REPEAT_CYCLES > 0) ? $clog2(REPEAT_CYCLES + 1) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] REP_MAX  = HW'(REPEAT_CYCLES);
    localparam bit            REP_EN   = (REPEAT_CYCLES > 0);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic          stable_prev_q;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          press, rep;

    always_comb begin
        stable_d  = stable_q;
        deb_cnt_d = deb_cnt_q;
        if (sync2_q == stable_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
            stable_d  = sync2_q;
            deb_cnt_d = '0;
        end else begin
            deb_cnt_d = deb_cnt_q + DW'(1);
        end
    end

    // Only the released-to-pressed transition is an event.
    assign press = stable_prev_q & ~stable_q;

    // The hold counter is 0 in the press cycle and reaches REP_MAX exactly
    // REPEAT_CYCLES cycles later; reloading with 1 keeps the same spacing.
    always_comb begin
        hold_d = '0;
        rep    = 1'b0;
        if (REP_EN && !stable_q) begin
            if (hold_q == REP_MAX) begin
                rep    = 1'b1;
                hold_d = HW'(1);
            end else begin
                hold_d = hold_q + HW'(1);
            end
        end
    end

    assign event_o = press | rep;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            stable_q      <= 1'b1;
            stable_prev_q <= 1'b1;
            deb_cnt_q     <= '0;
            hold_q        <= '0;
        end else begin
            sync1_q       <= key_ni;
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            deb_cnt_q     <= deb_cnt_d;
            hold_q        <= hold_d;
        end
    end
endmodule

module debug_selector #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_CYCLES   = 25_000_000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       KEY_UP,
    input  logic       KEY_DOWN,
    input  logic [7:0] DSW,
    output logic [7:0] SEL,
    output logic [2:0] MODE,
    output logic       CHANGE
);
    logic       up_ev, dn_ev;
    logic [2:0] mode_q, mode_d;
    logic [7:0] sel_q, sel_d;
    logic       change_q, change_d;

    function automatic logic [7:0] mode_code(input logic [2:0] m);
        logic [7:0] c;
        case (m)
            3'd0:    c = 8'h00;
            3'd1:    c = 8'h01;
            3'd2:    c = 8'h02;
            3'd3:    c = 8'h04;
            3'd4:    c = 8'h10;
            3'd5:    c = 8'h20;
            3'd6:    c = 8'h40;
            default: c = 8'h80;
        endcase
        return c;
    endfunction

    debug_selector_key #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_key_up (
        .clk_i  (CLK),
        .rst_i  (RESET),
        .key_ni (KEY_UP),
        .event_o(up_ev)
    );

    debug_selector_key #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_key_down (
        .clk_i  (CLK),
        .rst_i  (RESET),
        .key_ni (KEY_DOWN),
        .event_o(dn_ev)
    );

    always_comb begin
        mode_d = mode_q;
        case ({up_ev, dn_ev})
            2'b10:   mode_d = mode_q + 3'd1;
            2'b01:   mode_d = mode_q - 3'd1;
            2'b11:   mode_d = 3'd0;
            default: mode_d = mode_q;
        endcase
        change_d = (mode_d != mode_q);
        // Table code is taken from the next mode so SEL moves with MODE.
        sel_d = (DSW != 8'h00) ? DSW : mode_code(mode_d);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            mode_q   <= 3'd0;
            sel_q    <= 8'h00;
            change_q <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            sel_q    <= sel_d;
            change_q <= change_d;
        end
    end

    assign MODE   = mode_q;
    assign SEL    = sel_q;
    assign CHANGE = change_q;
endmodule

// File: tb/tb_debug_selector.sv
module tb_debug_selector;
    logic       CLK = 1'b0;
    logic       RESET;
    logic       KEY_UP;
    logic       KEY_DOWN;
    logic [7:0] DSW;
    logic [7:0] SEL;
    logic [2:0] MODE;
    logic       CHANGE;

    int n_cmp = 0;
    int n_err = 0;
    logic [2:0] sb[$];

    debug_selector #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_CYCLES  (16)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .KEY_UP  (KEY_UP),
        .KEY_DOWN(KEY_DOWN),
        .DSW     (DSW),
        .SEL     (SEL),
        .MODE    (MODE),
        .CHANGE  (CHANGE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock edge; outputs sampled 1 time unit later. Every CHANGE pulse
    // is matched against the next expected mode in the scoreboard.
    task automatic tick();
        logic [2:0] e;
        @(posedge CLK);
        #1;
        if (CHANGE === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_change", {5'b0, MODE}, 8'hFF);
            end else begin
                e = sb.pop_front();
                check("change_mode", {5'b0, MODE}, {5'b0, e});
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press(input bit up, input bit dn, input int low, input int high);
        KEY_UP   = ~up;
        KEY_DOWN = ~dn;
        ticks(low);
        KEY_UP   = 1'b1;
        KEY_DOWN = 1'b1;
        ticks(high);
    endtask

    initial begin
        logic [2:0] m;
        RESET    = 1'b1;
        KEY_UP   = 1'b1;
        KEY_DOWN = 1'b1;
        DSW      = 8'h00;

        // Reset
        ticks(3);
        check("rst_sel", SEL, 8'h00);
        check("rst_mode", {5'b0, MODE}, 8'h00);
        check("rst_change", {7'b0, CHANGE}, 8'h00);
        RESET = 1'b0;
        ticks(2);

        // Single step up with exact latency
        KEY_UP = 1'b0;
        sb.push_back(3'd1);
        ticks(6);
        check("up_e6_mode", {5'b0, MODE}, 8'h00);
        check("up_e6_change", {7'b0, CHANGE}, 8'h00);
        tick();
        check("up_e7_change", {7'b0, CHANGE}, 8'h01);
        check("up_e7_sel", SEL, 8'h01);
        tick();
        check("up_e8_change", {7'b0, CHANGE}, 8'h00);
        ticks(2);
        KEY_UP = 1'b1;
        ticks(12);
        check("up_mode", {5'b0, MODE}, 8'h01);

        // Return to 0, then glitch of 3 cycles is ignored
        sb.push_back(3'd0);
        press(1'b0, 1'b1, 6, 12);
        press(1'b0, 1'b1, 3, 12);
        check("glitch_mode", {5'b0, MODE}, 8'h00);

        // Down wrap 0 -> 7
        sb.push_back(3'd7);
        press(1'b0, 1'b1, 6, 12);
        check("wrap_dn_mode", {5'b0, MODE}, 8'h07);
        check("wrap_dn_sel", SEL, 8'h80);

        // Eight up presses return to 7, one CHANGE each
        m = 3'd7;
        for (int i = 0; i < 8; i++) begin
            m = m + 3'd1;
            sb.push_back(m);
            press(1'b1, 1'b0, 6, 10);
        end
        check("wrap_up_mode", {5'b0, MODE}, 8'h07);
        check("wrap_up_sel", SEL, 8'h80);

        // 7 -> 0, then hold-to-repeat
        sb.push_back(3'd0);
        press(1'b1, 1'b0, 6, 12);
        for (int v = 1; v <= 4; v++) sb.push_back(3'(v));
        KEY_UP = 1'b0;
        for (int e = 1; e <= 60; e++) begin
            tick();
            if (e == 7 || e == 23 || e == 39 || e == 55)
                check($sformatf("rep_e%0d_change", e), {7'b0, CHANGE}, 8'h01);
            if (e == 22)
                check("rep_e22_mode", {5'b0, MODE}, 8'h01);
        end
        KEY_UP = 1'b1;
        ticks(12);
        check("rep_mode", {5'b0, MODE}, 8'h04);
        check("rep_sel", SEL, 8'h10);

        // 4 -> 5, then both keys together -> 0
        sb.push_back(3'd5);
        press(1'b1, 1'b0, 6, 12);
        sb.push_back(3'd0);
        press(1'b1, 1'b1, 6, 12);
        check("both_mode", {5'b0, MODE}, 8'h00);
        check("both_sel", SEL, 8'h00);
        // Both keys again at mode 0: no CHANGE expected
        press(1'b1, 1'b1, 6, 12);
        check("both0_mode", {5'b0, MODE}, 8'h00);

        // Override
        sb.push_back(3'd1);
        press(1'b1, 1'b0, 6, 12);
        sb.push_back(3'd2);
        press(1'b1, 1'b0, 6, 12);
        check("ovr_pre_sel", SEL, 8'h02);
        DSW = 8'h20;
        tick();
        check("ovr_sel", SEL, 8'h20);
        sb.push_back(3'd3);
        press(1'b1, 1'b0, 6, 12);
        check("ovr_mode", {5'b0, MODE}, 8'h03);
        check("ovr_hold_sel", SEL, 8'h20);
        DSW = 8'h00;
        tick();
        check("ovr_clr_sel", SEL, 8'h04);

        // Reset while KEY_UP held
        KEY_UP = 1'b0;
        ticks(3);
        RESET = 1'b1;
        ticks(2);
        check("midrst_mode", {5'b0, MODE}, 8'h00);
        check("midrst_sel", SEL, 8'h00);
        check("midrst_change", {7'b0, CHANGE}, 8'h00);
        RESET = 1'b0;
        sb.push_back(3'd1);
        ticks(6);
        check("midrst_e6_mode", {5'b0, MODE}, 8'h00);
        tick();
        check("midrst_e7_mode", {5'b0, MODE}, 8'h01);
        check("midrst_e7_change", {7'b0, CHANGE}, 8'h01);
        KEY_UP = 1'b1;
        ticks(12);

        check("sb_pending", 8'(sb.size()), 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
